// File: rtl/counter_run_ctrl.sv
// Run controller for the 8-bit free-running counter: synchronises and debounces the start/stop
// buttons and drives the counter enables. Define COUNTER_RUN_CTRL_LIMIT_EN to build auto-halt.
module counter_run_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned COUNT_W         = 8
) (
    input  logic               i_clk,
    input  logic               i_arst,
    input  logic               i_btn_start,
    input  logic               i_btn_stop,
    input  logic [COUNT_W-1:0] i_count,
    input  logic [COUNT_W-1:0] i_limit,
    output logic               o_start,
    output logic               o_stop,
    output logic [1:0]         o_state,
    output logic               o_limit_hit
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StHalt = 2'b10
    } state_e;

    localparam logic [7:0] DbLast = 8'(DEBOUNCE_CYCLES - 1);

    // Bit 0 carries the start button, bit 1 the stop button.
    logic [1:0] sync1_q, sync2_q;
    logic [1:0] db_q, db_d;
    logic [1:0] press;
    logic [7:0] db_cnt_q [2];
    logic [7:0] db_cnt_d [2];

    state_e state_q, state_d;
    logic   start_q, start_d;
    logic   stop_q, stop_d;
    logic   hit_q, hit_d;
    logic   halt_cond;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            db_q        <= '0;
            db_cnt_q[0] <= '0;
            db_cnt_q[1] <= '0;
        end else begin
            sync1_q     <= {i_btn_stop, i_btn_start};
            sync2_q     <= sync1_q;
            db_q        <= db_d;
            db_cnt_q[0] <= db_cnt_d[0];
            db_cnt_q[1] <= db_cnt_d[1];
        end
    end

    // Press fires in the cycle before the debounced level rises, so the FSM acts on the same edge.
    always_comb begin
        db_d  = db_q;
        press = '0;
        for (int i = 0; i < 2; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DbLast) begin
                    db_d[i]  = sync2_q[i];
                    press[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 8'd1;
                end
            end
        end
    end

`ifdef COUNTER_RUN_CTRL_LIMIT_EN
    // Halt one count early: the counter still increments on this edge and stops at i_limit.
    assign halt_cond = (i_limit != '0) && (i_count == i_limit - COUNT_W'(1));
`else
    logic unused_limit_inputs;
    assign unused_limit_inputs = ^{i_count, i_limit};
    assign halt_cond = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        hit_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (press[0] && !press[1]) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (press[1]) begin
                    state_d = StIdle;
                end else if (halt_cond) begin
                    state_d = StHalt;
                    hit_d   = 1'b1;
                end
            end
            StHalt: begin
                if (press[1]) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        start_d = (state_d == StRun);
        stop_d  = !start_d;
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q <= StIdle;
            start_q <= 1'b0;
            stop_q  <= 1'b1;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            hit_q   <= hit_d;
        end
    end

    assign o_start     = start_q;
    assign o_stop      = stop_q;
    assign o_state     = state_q;
    assign o_limit_hit = hit_q;

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Bench for counter_run_ctrl: directed scenarios plus random button activity, checked each cycle
// against a history-based reference model. Follows COUNTER_RUN_CTRL_LIMIT_EN like the design.
module tb_counter_run_ctrl;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       arst = 1'b0;
    logic       btn_start, btn_stop;
    logic [7:0] cnt, lim;
    logic       o_start, o_stop, o_limit_hit;
    logic [1:0] o_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: raw samples since reset release, debounced levels, FSM state as 0/1/2.
    bit rs[$];
    bit rp[$];
    int m_n;
    bit m_db_s, m_db_p;
    int m_state;
    bit m_hit;

    bit         saw_hit, saw_wrap;
    logic [7:0] prev_cnt;

    always #5 clk = ~clk;

    counter_run_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .COUNT_W        (8)
    ) dut (
        .i_clk      (clk),
        .i_arst     (arst),
        .i_btn_start(btn_start),
        .i_btn_stop (btn_stop),
        .i_count    (cnt),
        .i_limit    (lim),
        .o_start    (o_start),
        .o_stop     (o_stop),
        .o_state    (o_state),
        .o_limit_hit(o_limit_hit)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Synchronised level seen during the cycle that ends at edge e (edges numbered from 1).
    function automatic bit sync_before(input bit btn, input int e);
        if (e < 3) return 1'b0;
        return btn ? rp[e-3] : rs[e-3];
    endfunction

    // Level is accepted when the last D synchronised cycles all disagree with it.
    function automatic bit flips(input bit btn, input int e, input bit db);
        if (e < D) return 1'b0;
        for (int j = 0; j < D; j++) begin
            if (sync_before(btn, e - j) == db) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_n     = 0;
        m_db_s  = 1'b0;
        m_db_p  = 1'b0;
        m_state = 0;
        m_hit   = 1'b0;
        rs.delete();
        rp.delete();
    endtask

    task automatic model_edge();
        bit fs, fp, ev_s, ev_p;
        int nxt;
        m_n++;
        fs   = flips(1'b0, m_n, m_db_s);
        fp   = flips(1'b1, m_n, m_db_p);
        ev_s = fs && !m_db_s;
        ev_p = fp && !m_db_p;
        if (fs) m_db_s = !m_db_s;
        if (fp) m_db_p = !m_db_p;
        rs.push_back(btn_start);
        rp.push_back(btn_stop);
        m_hit = 1'b0;
        nxt   = m_state;
        if (ev_p) nxt = 0;
        else if (m_state == 0 && ev_s) nxt = 1;
`ifdef COUNTER_RUN_CTRL_LIMIT_EN
        else if (m_state == 1 && lim != 8'd0 && ((int'(cnt) + 1) % 256) == int'(lim)) begin
            nxt   = 2;
            m_hit = 1'b1;
        end
`endif
        m_state = nxt;
    endtask

    task automatic tick();
        bit run_pre;
        run_pre = o_start && !o_stop;
        @(posedge clk);
        if (!arst) model_edge();
        #1;
        if (!arst && run_pre) cnt = cnt + 8'd1;
        check_eq("o_state", int'(o_state), m_state);
        check_eq("o_start", int'(o_start), int'(m_state == 1));
        check_eq("o_stop", int'(o_stop), int'(m_state != 1));
        check_eq("o_limit_hit", int'(o_limit_hit), int'(m_hit));
    endtask

    // Asynchronous reset raised and released between edges.
    task automatic do_reset();
        #2 arst = 1'b1;
        model_reset();
        #1;
        check_eq("rst_start", int'(o_start), 0);
        check_eq("rst_stop", int'(o_stop), 1);
        check_eq("rst_state", int'(o_state), 0);
        check_eq("rst_hit", int'(o_limit_hit), 0);
        tick();
        tick();
        #2 arst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        btn_start = 1'b0;
        btn_stop  = 1'b0;
        cnt       = 8'd0;
        lim       = 8'd0;
        model_reset();
        do_reset();

        // Start latency: accepted at edge 2+D.
        btn_start = 1'b1;
        repeat (1 + D) tick();
        check_eq("lat_before", int'(o_state), 0);
        tick();
        check_eq("lat_state", int'(o_state), 1);
        check_eq("lat_start", int'(o_start), 1);

        // Simultaneous start and stop while running: stop wins.
        btn_start = 1'b0;
        repeat (2 * D + 4) tick();
        btn_start = 1'b1;
        btn_stop  = 1'b1;
        repeat (1 + D) tick();
        check_eq("prio_before", int'(o_state), 1);
        tick();
        check_eq("prio_state", int'(o_state), 0);
        check_eq("prio_stop", int'(o_stop), 1);
        btn_start = 1'b0;
        btn_stop  = 1'b0;
        repeat (2 * D + 4) tick();

        // Glitch of D-1 cycles is ignored.
        do_reset();
        btn_start = 1'b1;
        repeat (D - 1) tick();
        btn_start = 1'b0;
        repeat (2 * D + 4) tick();
        check_eq("glitch_state", int'(o_state), 0);
        check_eq("glitch_start", int'(o_start), 0);

        // Auto-halt at limit 10.
        do_reset();
        cnt       = 8'd0;
        lim       = 8'd10;
        btn_start = 1'b1;
`ifdef COUNTER_RUN_CTRL_LIMIT_EN
        for (int i = 0; i < 80 && o_state != 2'b10; i++) tick();
        check_eq("halt_state", int'(o_state), 2);
        check_eq("halt_count", int'(cnt), 10);
        check_eq("halt_hit", int'(o_limit_hit), 1);
        tick();
        check_eq("hit_pulse", int'(o_limit_hit), 0);
        check_eq("halt_hold", int'(cnt), 10);
        btn_start = 1'b0;
        repeat (2 * D + 4) tick();
        btn_start = 1'b1;
        repeat (2 * D + 4) tick();
        check_eq("halt_ign_start", int'(o_state), 2);
        check_eq("halt_ign_count", int'(cnt), 10);
        btn_start = 1'b0;
        btn_stop  = 1'b1;
        repeat (2 * D + 4) tick();
        check_eq("halt_stop", int'(o_state), 0);
        btn_stop = 1'b0;
`else
        saw_hit  = 1'b0;
        saw_wrap = 1'b0;
        repeat (300) begin
            prev_cnt = cnt;
            tick();
            if (o_limit_hit) saw_hit = 1'b1;
            if (prev_cnt == 8'd255 && cnt == 8'd0) saw_wrap = 1'b1;
        end
        check_eq("nolim_wrap", int'(saw_wrap), 1);
        check_eq("nolim_hit", int'(saw_hit), 0);
        check_eq("nolim_state", int'(o_state), 1);
`endif
        btn_start = 1'b0;

        // Random button activity with occasional resets and limit changes.
        repeat (400) begin
            if ($urandom_range(0, 39) == 0) do_reset();
            if (m_state != 1 && $urandom_range(0, 4) == 0) begin
                lim = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'(cnt + $urandom_range(1, 20));
            end
            btn_start = ($urandom_range(0, 2) == 0);
            btn_stop  = ($urandom_range(0, 5) == 0);
            repeat ($urandom_range(1, 2 * D + 2)) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_run_ctrl.md
Name: counter_run_ctrl

Overview:
Run controller that sits directly upstream of the 8-bit free-running counter and drives its start/stop enables.
- Synchronises and debounces two raw push-button inputs.
- Tracks run state in a small FSM.
- Optionally auto-halts the counter when the count reaches a programmable limit, using the counter's count output as feedback.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronised cycles an input must hold a new level before it is accepted (legal range 1..255)
COUNT_W, 8, width of i_count and i_limit

Ports:
i_clk  input  1  clock, rising edge
i_arst  input  1  reset, asynchronous, active-high
i_btn_start  input  1  raw start button, asynchronous to i_clk
i_btn_stop  input  1  raw stop button, asynchronous to i_clk
i_count  input  COUNT_W  current count fed back from the counter's registered output
i_limit  input  COUNT_W  auto-halt limit, quasi-static; 0 disables auto-halt
o_start  output  1  counter start enable
o_stop  output  1  counter stop enable
o_state  output  2  FSM state: 00 IDLE, 01 RUN, 10 HALT
o_limit_hit  output  1  one-cycle pulse on entry to HALT

Behaviour:
- Reset is i_arst, asynchronous, active-high; clock is i_clk. All flops clear on reset.
- Reset values: o_start=0, o_stop=1, o_state=IDLE, o_limit_hit=0. Synchroniser and debounced levels = 0; debounce counters = 0.
- Synchroniser: 2 flops per button. The synchronised level is valid 2 edges after the raw input changes.
- Debounce, per button:
  - A counter increments each cycle the synchronised level differs from the debounced level.
  - The counter clears on any cycle where they match.
  - When the counter is DEBOUNCE_CYCLES-1 and the mismatch persists, the debounced level flips at the next edge and the counter clears.
  - A press event is generated combinationally on the cycle the debounced level flips 0->1.
- Latency: the first edge sampling the raw input high is edge 1. The press event is acted on at edge 2+DEBOUNCE_CYCLES.
- A raw glitch shorter than DEBOUNCE_CYCLES synchronised cycles is ignored. Releases (1->0) produce no event.
- FSM, with registered outputs updated at the same edge as the state:
  - IDLE: start event -> RUN.
  - RUN: stop event -> IDLE. Auto-halt condition -> HALT.
  - HALT: stop event -> IDLE. Start event is ignored.
- Output decode:
  - RUN: o_start=1, o_stop=0.
  - IDLE and HALT: o_start=0, o_stop=1.
- Simultaneous start and stop events: stop wins. IDLE stays IDLE; RUN goes to IDLE.
- Auto-halt condition: state==RUN, i_limit!=0, and i_count==i_limit-1 (mod 2^COUNT_W).
  - The counter increments at that same edge, so it stops holding exactly i_limit.
  - Comparison is equality only; a count already past the limit runs until wrap-around brings it back.
  - A stop event in the same cycle takes priority: go to IDLE, no o_limit_hit.
- o_limit_hit is registered. It is high for exactly the one cycle following the RUN->HALT edge.
- Reset mid-operation: immediate return to reset values. Debounce history is lost; a button still held after reset release creates a new press event after the normal latency.

Optional Feature:
Macro: COUNTER_RUN_CTRL_LIMIT_EN.
- Defined: auto-halt logic, the HALT state and o_limit_hit are built as described above.
- Undefined: i_limit and i_count are ignored, HALT is unreachable, and o_limit_hit is tied 0. The port list is unchanged.

Test Plan:
- Reset: assert i_arst mid-cycle -> outputs immediately o_start=0, o_stop=1, o_state=00, o_limit_hit=0.
- Start latency (DEBOUNCE_CYCLES=4): raise i_btn_start, sampled high at edge 1 and held -> o_start=1, o_state=01 after edge 6, not before.
- Glitch reject: i_btn_start high for 3 cycles then low -> o_start stays 0, o_state stays 00.
- Stop priority: press both buttons in the same cycle while in RUN -> o_state=00 and o_stop=1 after edge 6 of the press.
- Auto-halt (macro defined): i_limit=10, start, counter model increments on o_start && !o_stop -> count holds 10, o_state=10, o_limit_hit high for exactly 1 cycle. A subsequent start press is ignored; a stop press -> IDLE.
- Macro undefined: same stimulus with i_limit=10 -> count passes 10 and wraps 255->0, o_state stays 01, o_limit_hit never asserts.
